operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read stage that sits directly upstream of the ALU.
- Accepts a decoded ALU instruction over a valid/ready handshake and reads both source operands from an internal register file.
- Selects either rs2 or an immediate as the right operand, then presents opcode, left and right as registered outputs that drive the ALU's opcode, left and right inputs.
- Takes the writeback port from downstream, with same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, data width of registers, operands and immediate.
- NREGS, 32, number of architectural registers. Register index width is 5 bits, fixed. NREGS must be at most 32.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_opcode  in  3  ALU opcode (000 ADD, 100 SUB, 111 AND, ...); passed through unchanged.
- in_rs1  in  5  left source register index.
- in_rs2  in  5  right source register index.
- in_rd  in  5  destination register index; passed through.
- in_imm  in  XLEN  immediate value.
- in_use_imm  in  1  1 selects in_imm as the right operand instead of rs2.
- wb_en  in  1  writeback enable.
- wb_rd  in  5  writeback register index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operands valid toward the ALU.
- out_ready  in  1  downstream consumes this cycle.
- out_opcode  out  3  registered opcode to the ALU.
- out_left  out  XLEN  registered left operand.
- out_right  out  XLEN  registered right operand.
- out_rd  out  5  registered destination index.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All registers are cleared to 0.
  - out_valid=0, and out_opcode/out_left/out_right/out_rd are set to 0.
  - Any in-flight instruction and any writeback in the same cycle are discarded; reset wins over all other events.
- Register x0:
  - Always reads 0.
  - Writebacks with wb_rd=0 are ignored for storage and for bypass.
  - Indices at or above NREGS read 0; writes to them are ignored.
- Writeback: when wb_en=1, the register file is written at the clk edge, whatever the handshake state.
- Read value of index r: if wb_en && wb_rd==r && r!=0, the value is wb_data (bypass); otherwise it is the stored value. The read path is combinational.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept: when in_valid && in_ready, at the edge the stage captures:
  - out_opcode=in_opcode and out_rd=in_rd.
  - out_left=read(in_rs1).
  - out_right=in_use_imm ? in_imm : read(in_rs2).
  - out_valid=1.
  - Latency is exactly 1 cycle; full throughput of one instruction per cycle while out_ready=1.
- Drain: out_valid && out_ready && !in_valid sets out_valid=0 at the next edge. Data outputs keep their last values.
- Stall: out_valid && !out_ready holds out_valid, out_opcode and out_rd. The stage also stores the held rs1, rs2 and use_imm internally.
- Stall refresh:
  - During a stall, a writeback with wb_en && wb_rd!=0 && wb_rd==held rs1 updates out_left to wb_data at that edge.
  - Likewise for held rs2 into out_right, only when held use_imm=0.
  - If both match, both operands update.
  - This keeps operands coherent without an upstream interlock.
- No refresh occurs when out_valid=0.
- Simultaneous accept and writeback to a source index: the bypass value is captured, not the old stored value.
- Arithmetic: none. Operands are passed at full XLEN width with no extension. in_imm is already sign-extended by the decoder.

Test Plan:
- Reset and x0:
  - Stimulus: hold resetn=0 for 2 cycles, then write x0=0xDEADBEEF, then issue rs1=0, rs2=0, use_imm=0.
  - Required response: out_left=0, out_right=0, out_valid=1 one cycle after accept.
- Basic issue, feeding the ALU:
  - Stimulus: write x1=4, x2=3, then issue opcode=000, rs1=1, rs2=2, rd=5.
  - Required response: next cycle out_opcode=000, out_left=4, out_right=3, out_rd=5, out_valid=1.
  - An attached ALU must produce result=7.
- Immediate select:
  - Stimulus: x3=7; issue opcode=100, rs1=3, use_imm=1, imm=3.
  - Required response: out_left=7, out_right=3.
  - Also drive rs2 to a register holding 0xFFFFFFFF; out_right must still be 3.
- Same-cycle bypass:
  - Stimulus: in one cycle, wb x4=0xC plus issue rs1=4, rs2=4 with x4 previously 0.
  - Required response: out_left=out_right=0xC.
- Backpressure and refresh:
  - Stimulus: issue rs1=6, rs2=7 (x6=1, x7=2) with out_ready=0; hold for 3 cycles, writing x7=0xA in the 2nd cycle.
  - Required response: out_valid stays 1, in_ready=0, out_left=1, out_right=0xA from the following cycle on.
  - Then raise out_ready with in_valid=0; out_valid=0 the next cycle.
- Back-to-back throughput and reset mid-operation:
  - Stimulus: 4 consecutive issues with out_ready=1.
  - Required response: 4 consecutive out_valid cycles with matching operands.
  - Then assert resetn=0 while out_valid=1 and out_ready=0: out_valid=0 and all registers read 0 after the edge.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage feeding the ALU, with writeback bypass and stall-time operand refresh.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_opcode,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_opcode,
  output logic [XLEN-1:0] out_left,
  output logic [XLEN-1:0] out_right,
  output logic [4:0]      out_rd
);
  logic [XLEN-1:0] r_rf [NREGS];
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic            r_use_imm;
  logic            w_wb_ok;
  logic            w_accept;
  logic            w_stall;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  // x0 and indices beyond the implemented file are hardwired to zero
  function automatic logic idx_ok(input logic [4:0] r);
    return r != 5'd0 && 32'(r) < NREGS;
  endfunction
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] r);
    return !idx_ok(r) ? '0 : (w_wb_ok && wb_rd == r) ? wb_data : r_rf[r];
  endfunction
  assign w_wb_ok   = wb_en && idx_ok(wb_rd);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_stall   = out_valid && !out_ready;
  assign w_rs1_val = rd_reg(in_rs1);
  assign w_rs2_val = rd_reg(in_rs2);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_rd     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_use_imm  <= 1'b0;
    end else begin
      if (w_wb_ok) r_rf[wb_rd] <= wb_data;
      if (w_accept) begin
        out_valid  <= 1'b1;
        out_opcode <= in_opcode;
        out_rd     <= in_rd;
        out_left   <= w_rs1_val;
        out_right  <= in_use_imm ? in_imm : w_rs2_val;
        r_rs1      <= in_rs1;
        r_rs2      <= in_rs2;
        r_use_imm  <= in_use_imm;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        // held operands track writebacks so the ALU never sees a stale source
        if (w_stall && w_wb_ok && wb_rd == r_rs1) out_left <= wb_data;
        if (w_stall && w_wb_ok && !r_use_imm && wb_rd == r_rs2) out_right <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized scoreboard bench for operand_fetch against an architectural register model.
module tb_operand_fetch;
  logic        clk = 0;
  logic        resetn = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  in_opcode = 0;
  logic [4:0]  in_rs1 = 0;
  logic [4:0]  in_rs2 = 0;
  logic [4:0]  in_rd = 0;
  logic [31:0] in_imm = 0;
  logic        in_use_imm = 0;
  logic        wb_en = 0;
  logic [4:0]  wb_rd = 0;
  logic [31:0] wb_data = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [2:0]  out_opcode;
  logic [31:0] out_left;
  logic [31:0] out_right;
  logic [4:0]  out_rd;

  operand_fetch #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_left(out_left), .out_right(out_right), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_imm;
    logic [31:0] imm;
  } item_t;

  item_t       q[$];
  logic [31:0] regs[32];
  logic        exp_valid = 0;
  logic        mon_en = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural reference: an instruction presented to the ALU always carries
  // the current architectural value of its sources (or the immediate).
  function automatic logic [31:0] arch(input logic [4:0] r);
    return r == 0 ? 32'd0 : regs[r];
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      foreach (regs[i]) regs[i] = 0;
      exp_valid = 0;
      q.delete();
    end else begin
      if (in_valid && (!exp_valid || out_ready)) begin
        q.push_back('{in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm});
        exp_valid = 1;
      end else if (out_ready) exp_valid = 0;
      if (wb_en && wb_rd != 0) regs[wb_rd] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      item_t it;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !exp_valid || out_ready});
      if (exp_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty actual=valid required=queued_item at %0t", $time);
        end else begin
          it = q[0];
          chk("out_opcode", {29'd0, out_opcode}, {29'd0, it.opcode});
          chk("out_rd", {27'd0, out_rd}, {27'd0, it.rd});
          chk("out_left", out_left, arch(it.rs1));
          chk("out_right", out_right, it.use_imm ? it.imm : arch(it.rs2));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    in_valid = 0; wb_en = 1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [31:0] imm, input logic ui);
    in_valid = 1; in_opcode = op; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_imm = imm; in_use_imm = ui;
  endtask

  function automatic logic [4:0] pick();
    return ($urandom % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    resetn = 0;
    tick();
    mon_en = 1;
    tick();
    resetn = 1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_out_left", out_left, 0);
    chk("reset_out_right", out_right, 0);
    chk("reset_out_opcode", {29'd0, out_opcode}, 0);
    chk("reset_out_rd", {27'd0, out_rd}, 0);
    wb(0, 32'hDEADBEEF);
    set_issue(3'b000, 0, 0, 0, 0, 0); tick(); in_valid = 0;
    chk("x0_left", out_left, 0);
    chk("x0_right", out_right, 0);
    wb(1, 4); wb(2, 3);
    set_issue(3'b000, 1, 2, 5, 0, 0); tick(); in_valid = 0;
    chk("alu_add_result", out_left + out_right, 7);
    wb(3, 7); wb(8, 32'hFFFFFFFF);
    set_issue(3'b100, 3, 8, 1, 3, 1); tick(); in_valid = 0;
    chk("imm_right", out_right, 3);
    set_issue(3'b000, 4, 4, 2, 0, 0);
    wb_en = 1; wb_rd = 4; wb_data = 32'hC;
    tick(); in_valid = 0; wb_en = 0;
    chk("bypass_left", out_left, 32'hC);
    chk("bypass_right", out_right, 32'hC);
    wb(6, 1); wb(7, 2);
    out_ready = 0;
    set_issue(3'b111, 6, 7, 3, 0, 0); tick(); in_valid = 0;
    chk("stall_in_ready", {31'd0, in_ready}, 0);
    wb_en = 1; wb_rd = 7; wb_data = 32'hA; tick(); wb_en = 0;
    chk("refresh_right", out_right, 32'hA);
    chk("refresh_left", out_left, 1);
    tick();
    out_ready = 1; tick();
    chk("drain_valid", {31'd0, out_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      set_issue(3'(i), 5'(i + 1), 5'(i + 3), 5'(i), 32'(i), i[0]);
      tick();
    end
    out_ready = 0;
    set_issue(3'b001, 6, 7, 4, 0, 0); tick(); in_valid = 0;
    resetn = 0; tick(); resetn = 1;
    chk("midreset_valid", {31'd0, out_valid}, 0);
    out_ready = 1;
    set_issue(3'b000, 6, 7, 0, 0, 0); tick();
    chk("post_reset_left", out_left, 0);
    chk("post_reset_right", out_right, 0);
    set_issue(3'b000, 1, 3, 0, 0, 0); tick(); in_valid = 0;
    for (int n = 0; n < 3000; n++) begin
      resetn     = $urandom_range(0, 299) != 0;
      in_valid   = $urandom % 4 != 0;
      out_ready  = $urandom % 3 != 0;
      in_opcode  = 3'($urandom);
      in_rs1     = pick();
      in_rs2     = pick();
      in_rd      = 5'($urandom);
      in_imm     = $urandom;
      in_use_imm = 1'($urandom);
      wb_en      = 1'($urandom);
      wb_rd      = pick();
      wb_data    = $urandom;
      tick();
    end
    resetn = 1; in_valid = 0; wb_en = 0; out_ready = 1;
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
